// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush controller for the 5-stage pipeline.
// Latency: outputs combinational in RUN (same cycle), registered-state decode in HOLD;
// a loadBranchEx stall lasts 2 cycles, every other cause 1 cycle.
// Backpressure: freezes PC and IF/ID (PCWrite/IF_ID_write low) and bubbles ID/EX while stalling.
//
// Ports:
//   clk, rst_n            - pipeline clock (rising edge), synchronous active-low reset
//   IF_ID_rs/rt/useRt     - source operands of the instruction in ID
//   IF_ID_branch          - ID instruction is beq/bne; branchTaken is its comparator result
//   ID_EX_memRead/regWrite/rd - producer currently in EX
//   EX_MEM_memRead/rd     - producer currently in MEM
//   PCWrite, IF_ID_write  - 1 = PC / IF/ID may update
//   ID_EX_flush           - 1 = inject bubble into ID/EX
//   IF_ID_flush           - 1 = squash the fetched instruction (taken branch)
//   stall                 - OR of all stall causes
//
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating 16-bit stallCount and
// flushCount outputs; without it those ports and counters do not exist.

module hazard_detection_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       IF_ID_useRt,
    input  logic       IF_ID_branch,
    input  logic       branchTaken,
    input  logic       ID_EX_memRead,
    input  logic       ID_EX_regWrite,
    input  logic [4:0] ID_EX_rd,
    input  logic       EX_MEM_memRead,
    input  logic [4:0] EX_MEM_rd,
    output logic       PCWrite,
    output logic       IF_ID_write,
    output logic       ID_EX_flush,
    output logic       IF_ID_flush,
    output logic       stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Operand match: register 0 is hard-wired zero and never a hazard.
    // rt only counts when the ID instruction actually reads it.
    // ------------------------------------------------------------------
    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs) || (IF_ID_useRt && (ID_EX_rd == IF_ID_rt)));
        mem_match = (EX_MEM_rd != 5'd0) &&
                    ((EX_MEM_rd == IF_ID_rs) || (IF_ID_useRt && (EX_MEM_rd == IF_ID_rt)));
    end

    // ------------------------------------------------------------------
    // Stall causes. Non-branch consumers only wait on a load in EX (the
    // forwarding network covers everything else). Branches compare in ID,
    // so they also wait on ALU results in EX and on loads in MEM.
    // ------------------------------------------------------------------
    logic load_use;
    logic alu_branch;
    logic load_branch_ex;
    logic load_branch_mem;
    logic any_cause;

    always_comb begin
        load_use        = ID_EX_memRead && ex_match && !IF_ID_branch;
        alu_branch      = IF_ID_branch && ID_EX_regWrite && !ID_EX_memRead && ex_match;
        load_branch_ex  = IF_ID_branch && ID_EX_memRead && ex_match;
        load_branch_mem = IF_ID_branch && EX_MEM_memRead && mem_match;
        any_cause       = load_use || alu_branch || load_branch_ex || load_branch_mem;
    end

    // ------------------------------------------------------------------
    // Next state and outputs. A load feeding a branch needs the load to
    // reach WB before the ID comparator sees valid data, so RUN hands off
    // to HOLD for the second stall cycle. HOLD ignores the pipeline inputs
    // entirely: the bubble just injected makes them meaningless there.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b1;
        IF_ID_write = 1'b1;
        ID_EX_flush = 1'b0;
        IF_ID_flush = 1'b0;
        stall       = 1'b0;

        if (!rst_n) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (any_cause) begin
                        PCWrite     = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                        stall       = 1'b1;
                        // Longest stall wins when several causes coincide.
                        if (load_branch_ex) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        // Branch resolved on valid operands: squash the
                        // sequentially fetched instruction if taken.
                        IF_ID_flush = IF_ID_branch && branchTaken;
                    end
                end
                ST_HOLD: begin
                    PCWrite     = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                    stall       = 1'b1;
                    state_d     = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating event counters for performance observation.
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (IF_ID_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall/flush controller for the 5-stage pipelined CPU. Forwarding resolves producer-to-consumer dependencies by bypass; this block covers dependencies bypassing cannot resolve: load-use into EX and operand dependencies of branches resolved in ID. It freezes PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on taken branches. A small state machine sequences the two-cycle stall a load-to-branch dependency requires.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous reset, active low
- IF_ID_rs  in  5  source register rs of instruction in ID
- IF_ID_rt  in  5  source register rt of instruction in ID
- IF_ID_useRt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- IF_ID_branch  in  1  ID instruction is beq/bne
- branchTaken  in  1  ID comparator result, valid when IF_ID_branch=1
- ID_EX_memRead  in  1  instruction in EX is a load
- ID_EX_regWrite  in  1  instruction in EX writes a register
- ID_EX_rd  in  5  destination of instruction in EX (already muxed rt/rd)
- EX_MEM_memRead  in  1  instruction in MEM is a load
- EX_MEM_rd  in  5  destination of instruction in MEM
- PCWrite  out  1  1 = PC may update
- IF_ID_write  out  1  1 = IF/ID may load
- ID_EX_flush  out  1  1 = load bubble (zero control) into ID/EX
- IF_ID_flush  out  1  1 = clear IF/ID (squash fetched instruction)
- stall  out  1  OR of all stall causes (debug/observation)

## Operation
- Match(x) = (x != 0) and (x == IF_ID_rs or (IF_ID_useRt and x == IF_ID_rt)). Register 0 never causes a hazard.
- Causes, evaluated in state RUN:
  - loadUse: ID_EX_memRead and Match(ID_EX_rd) and not IF_ID_branch -> 1 stall cycle.
  - aluBranch: IF_ID_branch and ID_EX_regWrite and not ID_EX_memRead and Match(ID_EX_rd) -> 1 stall cycle.
  - loadBranchEx: IF_ID_branch and ID_EX_memRead and Match(ID_EX_rd) -> 2 stall cycles.
  - loadBranchMem: IF_ID_branch and EX_MEM_memRead and Match(EX_MEM_rd) -> 1 stall cycle.
- Stall cycle outputs: PCWrite=0, IF_ID_write=0, ID_EX_flush=1, stall=1, IF_ID_flush=0.
- Non-stall cycle: PCWrite=1, IF_ID_write=1, ID_EX_flush=0, stall=0; IF_ID_flush = IF_ID_branch and branchTaken.
- States: RUN, HOLD.
  - RUN: loadBranchEx -> HOLD; all other causes stay in RUN (next cycle re-evaluated from pipeline contents).
  - HOLD: stall outputs forced regardless of inputs; unconditional -> RUN.
- Priority: any stall cause suppresses IF_ID_flush (branch not resolved on stale operands). Multiple simultaneous causes -> longest stall (loadBranchEx).

## Timing
- Outputs are Mealy in RUN: combinational from inputs, same cycle; in HOLD, decode of registered state only.
- State is the only register: updates on rising clk.
- Reset: while rst_n=0, outputs forced PCWrite=1, IF_ID_write=1, ID_EX_flush=0, IF_ID_flush=0, stall=0; state <= RUN on the edge. Reset during HOLD aborts the stall; next cycle is RUN.
- loadBranchEx sequence: cycle N stall (RUN->HOLD), N+1 stall (HOLD->RUN), N+2 load is in WB, branch evaluates; IF_ID_flush asserts at N+2 if taken.
- Latency stall-to-release: 1 cycle for single-cycle causes, 2 for loadBranchEx.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stallCount[15:0] and flushCount[15:0]; each increments by 1 on every rising edge where stall / IF_ID_flush is 1, saturating at 16'hFFFF; cleared to 0 by rst_n=0.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Load-use: ID_EX_memRead=1, ID_EX_rd=5, IF_ID_rs=5, IF_ID_branch=0 -> one cycle PCWrite=0, IF_ID_write=0, ID_EX_flush=1; next cycle with ID_EX_memRead=0 -> PCWrite=1.
- Register 0: ID_EX_memRead=1, ID_EX_rd=0, IF_ID_rs=0 -> stall=0 every cycle.
- Load-to-branch: IF_ID_branch=1, ID_EX_memRead=1, ID_EX_rd=8, IF_ID_rt=8, IF_ID_useRt=1, branchTaken=1 -> stall=1 two consecutive cycles (inputs cleared in second cycle), IF_ID_flush=0 both; third cycle IF_ID_flush=1, stall=0.
- ALU-to-branch: IF_ID_branch=1, ID_EX_regWrite=1, ID_EX_memRead=0, ID_EX_rd=3, IF_ID_rs=3 -> exactly 1 stall cycle; IF_ID_useRt=0 with match only on rt -> no stall.
- Reset in HOLD: trigger loadBranchEx, assert rst_n=0 next cycle -> outputs PCWrite=1, stall=0 that cycle; after release, state RUN, no residual stall.
- With HAZARD_PERF_CNT_EN: one loadUse plus one loadBranchEx taken branch -> stallCount=3, flushCount=1.
